// File: rtl/eth_tx_framer_if.sv
// Byte-stream handshake between the packet sender and the Ethernet transmit framer.
interface eth_tx_framer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: prepends preamble/SFD, enforces the inter-frame gap and
// flags underrun/oversize frames with tx_er toward a GMII-style byte interface.
module eth_tx_framer #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned PREAMBLE_BYTES  = 7,
    parameter int unsigned IFG_BYTES       = 12,
    parameter int unsigned MAX_FRAME_BYTES = 1518
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            frame_req,
    eth_tx_framer_if.slave  s_axis,
    output logic [7:0]      tx_data,
    output logic            tx_en,
    output logic            tx_er,
    output logic            busy,
    output logic [15:0]     frame_count,
    output logic [7:0]      err_count
);
    localparam int unsigned CW = 11;
    localparam int unsigned TW = $clog2(PREAMBLE_BYTES + IFG_BYTES + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_SFD      = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;
    localparam logic [2:0] S_IFG      = 3'd5;

    logic [2:0]            state, state_n;
    logic [TW-1:0]         tcnt, tcnt_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [7:0]            tx_data_n;
    logic                  tx_en_n, tx_er_n;
    logic                  frame_inc, err_inc;
    logic [DATA_WIDTH-1:0] byte_in;

    assign byte_in       = s_axis.tdata;
    assign s_axis.tready = (state == S_SFD) || (state == S_DATA) || (state == S_DRAIN);
    assign busy          = (state != S_IDLE);

    // Next-state and next-pin values; the pins are registered, so each state
    // computes what the PHY sees in the following cycle.
    always_comb begin
        state_n   = state;
        tcnt_n    = tcnt;
        cnt_n     = cnt;
        tx_data_n = 8'h00;
        tx_en_n   = 1'b0;
        tx_er_n   = 1'b0;
        frame_inc = 1'b0;
        err_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n  = '0;
                tcnt_n = '0;
                if (frame_req || s_axis.tvalid) begin
                    state_n   = S_PREAMBLE;
                    tx_en_n   = 1'b1;
                    tx_data_n = 8'h55;
                end
            end
            S_PREAMBLE: begin
                cnt_n   = '0;
                tx_en_n = 1'b1;
                if (tcnt == TW'(PREAMBLE_BYTES - 1)) begin
                    tx_data_n = 8'hD5;
                    tcnt_n    = '0;
                    state_n   = S_SFD;
                end else begin
                    tx_data_n = 8'h55;
                    tcnt_n    = tcnt + TW'(1);
                end
            end
            S_SFD, S_DATA: begin
                state_n = S_DATA;
                tx_en_n = 1'b1;
                if (!s_axis.tvalid) begin
                    tx_er_n = 1'b1;
                    err_inc = 1'b1;
                    state_n = S_DRAIN;
                end else begin
                    tx_data_n = 8'(byte_in);
                    if (cnt < CW'(MAX_FRAME_BYTES)) begin
                        cnt_n = cnt + CW'(1);
                        if (s_axis.tlast) begin
                            frame_inc = 1'b1;
                            state_n   = S_IFG;
                        end
                    end else begin
                        tx_er_n = 1'b1;
                        err_inc = 1'b1;
                        state_n = s_axis.tlast ? S_IFG : S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (s_axis.tvalid && s_axis.tlast) state_n = S_IFG;
            end
            S_IFG: begin
                // Entered while the last byte is still on the pins, hence IFG_BYTES+1 cycles.
                if (tcnt == TW'(IFG_BYTES)) begin
                    tcnt_n = '0;
                    if (frame_req) begin
                        state_n   = S_PREAMBLE;
                        tx_en_n   = 1'b1;
                        tx_data_n = 8'h55;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tcnt        <= '0;
            cnt         <= '0;
            tx_data     <= 8'h00;
            tx_en       <= 1'b0;
            tx_er       <= 1'b0;
            frame_count <= 16'h0000;
            err_count   <= 8'h00;
        end else begin
            state   <= state_n;
            tcnt    <= tcnt_n;
            cnt     <= cnt_n;
            tx_data <= tx_data_n;
            tx_en   <= tx_en_n;
            tx_er   <= tx_er_n;
            if (frame_inc) frame_count <= frame_count + 16'd1;
            if (err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer: randomized frames against a frame-level model.
module tb_eth_tx_framer;
    localparam int MAXB = 1518;
    localparam int PRE  = 7;
    localparam int IFG  = 12;

    logic        clk, rst_n, frame_req;
    logic [7:0]  tx_data;
    logic        tx_en, tx_er, busy;
    logic [15:0] frame_count;
    logic [7:0]  err_count;

    eth_tx_framer_if #(.DATA_WIDTH(8)) s_axis ();

    eth_tx_framer dut (
        .clk(clk), .rst_n(rst_n), .frame_req(frame_req), .s_axis(s_axis),
        .tx_data(tx_data), .tx_en(tx_en), .tx_er(tx_er), .busy(busy),
        .frame_count(frame_count), .err_count(err_count)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [10:0] trace [$];
    logic [8:0]  exp_q [$];
    logic [8:0]  got_q [$];
    logic [7:0]  fbytes [0:2047];
    int          req_idx, first_en, first_busy, nruns, gap;
    logic [15:0] exp_frames;
    logic [7:0]  exp_errs;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pin trace, sampled shortly after each rising edge: {busy, tx_en, tx_er, tx_data}.
    always @(posedge clk) begin
        #2;
        trace.push_back({busy, tx_en, tx_er, tx_data});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] req);
        vectors++;
        assert (got === req) else begin
            miscompares++;
            $error("FAIL %s got=0x%0h required=0x%0h", tag, got, req);
        end
    endtask

    task automatic fill_random(input int n);
        for (int k = 0; k < n; k++) fbytes[k] = 8'($urandom);
    endtask

    // Frame-level model: what the PHY should see while tx_en is high, plus counter effect.
    task automatic build_exp(input int n, input int hole);
        bit bad = 1'b0;
        for (int k = 0; k < PRE; k++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        for (int k = 0; k < n; k++) begin
            if (k == hole) begin exp_q.push_back({1'b1, 8'h00}); bad = 1'b1; break; end
            if (k >= MAXB) begin exp_q.push_back({1'b1, fbytes[k]}); bad = 1'b1; break; end
            exp_q.push_back({1'b0, fbytes[k]});
        end
        if (bad) exp_errs = (exp_errs == 8'hFF) ? 8'hFF : exp_errs + 8'd1;
        else     exp_frames = exp_frames + 16'd1;
    endtask

    // Sender: offers bytes only while tready is high; optionally skips one beat (hole).
    task automatic send_frame(input int n, input int hole, input bit hold, input int abort_at);
        int  i = 0;
        int  guard = 0;
        bit  holed = 1'b0;
        @(negedge clk);
        if (!frame_req) req_idx = trace.size();
        frame_req = 1'b1;
        while (i < n && i != abort_at && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (!hold && i > 0) frame_req = 1'b0;
            s_axis.tvalid = 1'b0;
            s_axis.tlast  = 1'b0;
            if (s_axis.tready) begin
                if (i == hole && !holed) holed = 1'b1;
                else begin
                    s_axis.tdata  = fbytes[i];
                    s_axis.tvalid = 1'b1;
                    s_axis.tlast  = (i == n - 1);
                    i++;
                end
            end
        end
        chk("send_timeout", 32'(guard < 20000), 32'd1);
        if (i == abort_at) return;
        @(negedge clk);
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        if (!hold) frame_req = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        do begin @(negedge clk); g++; end while (busy && g < 5000);
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic analyze();
        got_q.delete();
        nruns = 0; first_en = -1; first_busy = -1; gap = 0;
        for (int k = 0; k < trace.size(); k++) begin
            if (trace[k][10] && first_busy < 0) first_busy = k;
            if (trace[k][9]) begin
                got_q.push_back(trace[k][8:0]);
                if (first_en < 0) first_en = k;
                if (k == 0 || !trace[k-1][9]) nruns++;
            end else if (nruns == 1) begin
                gap++;
            end
        end
    endtask

    task automatic cmp_q(input string tag);
        int bad = exp_q.size();
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            if (got_q[k] !== exp_q[k]) begin bad = k; break; end
        chk({tag, "_first_bad_idx"}, 32'(bad), 32'(exp_q.size()));
    endtask

    task automatic run_single(input string tag, input int n, input int hole);
        trace.delete();
        exp_q.delete();
        build_exp(n, hole);
        send_frame(n, hole, 1'b0, -1);
        wait_idle();
        analyze();
        cmp_q(tag);
        chk({tag, "_runs"}, 32'(nruns), 32'd1);
        chk({tag, "_start"}, 32'(first_en), 32'(req_idx));
        chk({tag, "_frames"}, 32'(frame_count), 32'(exp_frames));
        chk({tag, "_errs"}, 32'(err_count), 32'(exp_errs));
    endtask

    initial begin
        int n;
        rst_n = 1'b0; frame_req = 1'b0;
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; s_axis.tdata = 8'h00;
        exp_frames = 16'd0; exp_errs = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_tx_en", 32'(tx_en), 32'd0);
        chk("rst_tx_er", 32'(tx_er), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tready", 32'(s_axis.tready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_counts", {8'd0, frame_count, err_count}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic ramp frame
        for (int k = 0; k < 64; k++) fbytes[k] = 8'(k);
        run_single("basic", 64, -1);
        chk("basic_busy_start", 32'(first_busy), 32'(req_idx));

        // Random clean frames, including a one-byte frame
        for (int r = 0; r < 4; r++) begin
            n = (r == 0) ? 1 : int'($urandom_range(2, 200));
            fill_random(n);
            run_single("rand_clean", n, -1);
        end

        // Back-to-back frames with frame_req held high
        trace.delete(); exp_q.delete();
        fill_random(64); build_exp(64, -1);
        send_frame(64, -1, 1'b1, -1);
        fill_random(64); build_exp(64, -1);
        send_frame(64, -1, 1'b0, -1);
        wait_idle();
        analyze();
        cmp_q("b2b");
        chk("b2b_runs", 32'(nruns), 32'd2);
        chk("b2b_gap", 32'(gap), 32'(IFG));
        chk("b2b_frames", 32'(frame_count), 32'(exp_frames));

        // Underrun after byte 20, then a random hole position
        fill_random(64);
        run_single("underrun", 64, 20);
        n = int'($urandom_range(10, 120));
        fill_random(n);
        run_single("underrun_rand", n, int'($urandom_range(0, 9)));

        // Oversize: truncated at MAXB with tx_er, then a clean frame
        fill_random(1530);
        run_single("oversize", 1530, -1);
        fill_random(60);
        run_single("after_oversize", 60, -1);
        fill_random(MAXB);
        run_single("exact_max", MAXB, -1);
        fill_random(MAXB + 1);
        run_single("oversize_tlast", MAXB + 1, -1);

        // Reset during data byte 30
        fill_random(64);
        trace.delete();
        send_frame(64, -1, 1'b0, 30);
        @(posedge clk); #2;
        chk("pre_rst_en", 32'(tx_en), 32'd1);
        chk("pre_rst_byte", 32'(tx_data), 32'(fbytes[29]));
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_en", 32'(tx_en), 32'd0);
        chk("midrst_tx_er", 32'(tx_er), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_counts", {8'd0, frame_count, err_count}, 32'd0);
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; frame_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        exp_frames = 16'd0; exp_errs = 8'd0;
        fill_random(40);
        run_single("after_reset", 40, -1);

        // Error counter saturation
        for (int r = 0; r < 260; r++) begin
            trace.delete(); exp_q.delete();
            fill_random(4);
            build_exp(4, 1);
            send_frame(4, 1, 1'b0, -1);
            wait_idle();
        end
        chk("sat_errs", 32'(err_count), 32'hFF);
        chk("sat_errs_model", 32'(err_count), 32'(exp_errs));
        chk("sat_frames", 32'(frame_count), 32'(exp_frames));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

Ethernet transmit framer directly downstream of the TCP packet sender. It takes the sender's byte stream (Ethernet header through FCS, ending with `tlast` on the last CRC byte) and drives a GMII-style byte interface toward the PHY. It prepends the 7-byte preamble and the SFD, and enforces the inter-frame gap. Because the PHY side has no backpressure, it also flags underrun and oversize frames with `tx_er`.

## Interface
- `DATA_WIDTH`, default 8: stream byte width; only 8 is supported.
- `PREAMBLE_BYTES`, default 7: number of 0x55 bytes sent before the SFD.
- `IFG_BYTES`, default 12: minimum number of `tx_en`-low cycles between frames.
- `MAX_FRAME_BYTES`, default 1518: maximum frame bytes (DA through FCS) forwarded before a frame is truncated.
- `clk` in 1: the single clock; one byte per cycle.
- `rst_n` in 1: reset, asynchronous and active-low.
- `frame_req` in 1: frame pending; tie to the sender's `busy`.
- `s_axis_tdata` in DATA_WIDTH: frame byte.
- `s_axis_tvalid` in 1: byte valid.
- `s_axis_tready` out 1: byte accepted when high with `tvalid`.
- `s_axis_tlast` in 1: last FCS byte of the frame.
- `tx_data` out 8: byte to the PHY.
- `tx_en` out 1: transmit enable.
- `tx_er` out 1: transmit error; the PHY corrupts the frame.
- `busy` out 1: high when the state is not IDLE.
- `frame_count` out 16: frames completed without error; wraps at 0xFFFF.
- `err_count` out 8: aborted frames; saturates at 0xFF.

## Operation
- States: IDLE, PREAMBLE, SFD, DATA, DRAIN, IFG.
- IDLE:
  - `s_axis_tready`=0 and `tx_en`=0.
  - If `frame_req` or `s_axis_tvalid` is high, go to PREAMBLE.
  - The sender raises `tvalid` only while `tready` is high, so `frame_req` is the normal trigger.
- PREAMBLE: emit 0x55 for PREAMBLE_BYTES cycles, then go to SFD. `s_axis_tready`=0.
- SFD: emit 0xD5. `s_axis_tready`=1, so the first data byte is accepted in this cycle. Go to DATA.
- DATA: `s_axis_tready`=1. The byte counter `cnt` (11 bits) is cleared in IDLE.
  - `tvalid`=1 and `cnt` < MAX_FRAME_BYTES:
    - Forward the byte and increment `cnt`.
    - If `tlast`, increment `frame_count` and go to IFG.
  - `tvalid`=1 and `cnt` == MAX_FRAME_BYTES (oversize):
    - Forward the byte with `tx_er`=1 and increment `err_count`.
    - Go to IFG if `tlast`, otherwise to DRAIN.
  - `tvalid`=0 (underrun):
    - Emit one cycle of `tx_en`=1, `tx_er`=1, data 0x00, and increment `err_count`.
    - Go to DRAIN.
- DRAIN:
  - `s_axis_tready`=1 and `tx_en`=0.
  - Discard bytes until a beat with `tvalid`, `tready` and `tlast`, then go to IFG.
  - Error-counter increments happen once per frame only.
- IFG:
  - `tx_en`=0 and `s_axis_tready`=0 for exactly IFG_BYTES cycles, then go to IDLE.
  - If `frame_req` is high in the last IFG cycle, go directly to PREAMBLE.
  - This makes the gap exactly IFG_BYTES when back-to-back.
- The framer does no CRC, padding, or byte modification; data bytes pass through bit-exact.

## Timing
- Reset (asynchronous, immediate, including mid-frame):
  - `tx_en`, `tx_er`, `tx_data`, `s_axis_tready`, `busy`, `frame_count` and `err_count` go to 0.
  - The state goes to IDLE.
- Output pipeline:
  - `tx_data`, `tx_en` and `tx_er` are registered.
  - A byte accepted at edge N appears on `tx_data` in the cycle following edge N.
  - `s_axis_tready` is combinational from the state only and does not depend on `tvalid`.
- Trigger sampled high in IDLE in cycle T:
  - 0x55 on the pins in cycles T+1..T+7.
  - 0xD5 in T+8.
  - First data byte in T+9, provided `tvalid` was high in T+8.
- `tx_en` is continuous from the first preamble byte through the last FCS byte when there is no underrun.
- Last data byte on the pins in cycle L:
  - `tx_en`=0 in cycles L+1..L+12.
  - Earliest next preamble is in L+13.
- A `tlast` beat in the same cycle as the oversize condition ends the frame and goes to IFG, not DRAIN.
- `busy` is high from the cycle after the trigger through the last IFG cycle.
- Counter updates are visible one cycle after the deciding beat.

## Test plan
- **Basic frame.** Pulse `frame_req`, then stream 64 bytes 0x00..0x3F with `tlast` on 0x3F and no gaps.
  - Pins show 7×0x55, 0xD5, then 0x00..0x3F with `tx_en` continuous and `tx_er`=0.
  - `frame_count`=1.
- **Back-to-back frames.** Send two 64-byte frames with `frame_req` held high.
  - Exactly 12 `tx_en`-low cycles between the last byte of frame 1 and the first 0x55 of frame 2.
- **Underrun.** Drop `tvalid` for one cycle after data byte 20, then resume; `tlast` is at byte 64.
  - One cycle of `tx_en`=1, `tx_er`=1 after byte 20, then `tx_en`=0 while the remaining bytes are drained.
  - `err_count`=1, `frame_count`=0.
  - Followed by 12 idle cycles.
- **Oversize.** Stream 1530 bytes with MAX_FRAME_BYTES=1518.
  - Byte 1519 is output with `tx_er`=1, the rest are dropped, `err_count`=1.
  - The next normal frame transmits cleanly.
- **Reset mid-frame.** Assert `rst_n` low during data byte 30.
  - `tx_en` and `tx_er` go to 0 in the same cycle, `busy`=0, counters are 0.
  - The frame after release starts with a full preamble.
- **Saturation.** Run 260 underrun frames.
  - `err_count` holds 0xFF.
  - `frame_count` wraps from 0xFFFF to 0 when preloaded via a 65536-frame run or a forced value.
